// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared sizing constants and state encoding for the Fibonacci/BCD path
package fibo_pkg;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;
   localparam int IDXW   = 6;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

endpackage : fibo_pkg

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble adjuster: adds 3 when the digit is 5 or more
module bcd_add3 (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   always_comb begin
      d_o = d_i;
      if (d_i >= 4'd5) begin
         d_o = d_i + 4'd3;
      end
   end

endmodule : bcd_add3

// File: rtl/fibo_bcd_conv.sv
// rtl/fibo_bcd_conv.sv - sequential binary-to-BCD converter, one bit per cycle
module fibo_bcd_conv
   import fibo_pkg::*;
#(
   parameter int WIDTH  = fibo_pkg::WIDTH,
   parameter int DIGITS = fibo_pkg::DIGITS,
   parameter int IDXW   = fibo_pkg::IDXW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    value,
   input  logic [IDXW-1:0]     count,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic [IDXW-1:0]     index,
   output logic [3:0]          ndigits
);

   localparam int CW = $clog2(WIDTH);
   localparam int SW = 4 * DIGITS;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SW-1:0]     scr_q, scr_d;
   logic [WIDTH-1:0]  shf_q, shf_d;
   logic [IDXW-1:0]   tag_q, tag_d;
   logic [SW-1:0]     bcd_q, bcd_d;
   logic [IDXW-1:0]   index_q, index_d;
   logic [3:0]        nd_q, nd_d;
   logic              done_q, done_d;

   logic [SW-1:0]     scr_adj;
   logic [SW-1:0]     scr_next;
   logic [3:0]        nd_next;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (scr_q[4*g +: 4]),
         .d_o (scr_adj[4*g +: 4])
      );
   end

   // Top scratch bit falls off the shift; the top digit never exceeds 4 for legal sizes.
   assign scr_next = SW'({scr_adj, shf_q[WIDTH-1]});

   always_comb begin
      nd_next = 4'd1;
      for (int i = 1; i < DIGITS; i++) begin
         if (scr_next[4*i +: 4] != 4'd0) begin
            nd_next = 4'(i + 1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scr_d   = scr_q;
      shf_d   = shf_q;
      tag_d   = tag_q;
      bcd_d   = bcd_q;
      index_d = index_q;
      nd_d    = nd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shf_d   = value;
               tag_d   = count;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            scr_d = scr_next;
            shf_d = {shf_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               bcd_d   = scr_next;
               index_d = tag_q;
               nd_d    = nd_next;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         scr_q   <= '0;
         shf_q   <= '0;
         tag_q   <= '0;
         bcd_q   <= '0;
         index_q <= '0;
         nd_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scr_q   <= scr_d;
         shf_q   <= shf_d;
         tag_q   <= tag_d;
         bcd_q   <= bcd_d;
         index_q <= index_d;
         nd_q    <= nd_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == CONV);
   assign done    = done_q;
   assign bcd     = bcd_q;
   assign index   = index_q;
   assign ndigits = nd_q;

endmodule : fibo_bcd_conv
